// File: rtl/uart_frame_seq_if.sv
// Handshake bundle shared by the frame sequencer, its requester and the byte-level UART transmitter.
interface uart_frame_seq_if #(
    parameter int PAYLOAD_BYTES = 4
) ();
    logic                       snd;
    logic [8*PAYLOAD_BYTES-1:0] payload;
    logic                       tx_done;
    logic                       trmt;
    logic [7:0]                 tx_data;
    logic                       busy;
    logic                       frm_done;

    modport master (
        input  snd, payload, tx_done,
        output trmt, tx_data, busy, frm_done
    );

    modport slave (
        output snd, payload, tx_done,
        input  trmt, tx_data, busy, frm_done
    );
endinterface

// File: rtl/uart_frame_seq.sv
// Sends one telemetry frame (header, payload LSB byte first, inverted 8-bit sum) per accepted request,
// pacing each byte off the transmitter's tx_done flag.
module uart_frame_seq #(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input logic              clk,
    input logic              rst,
    uart_frame_seq_if.master bus
);
    localparam int            IW       = $clog2(PAYLOAD_BYTES + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]                 state;
    logic [IW-1:0]              idx;
    logic [7:0]                 csum;
    logic [8*PAYLOAD_BYTES-1:0] pay_q;
    logic [7:0]                 pay_byte;
    logic [7:0]                 cur_byte;

    always_comb begin
        pay_byte = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (idx == IW'(i + 1)) begin
                pay_byte = pay_q[8*i +: 8];
            end
        end
    end

    // Index 0 is the header, the last index carries the inverted running sum.
    always_comb begin
        if (idx == '0) begin
            cur_byte = HEADER;
        end else if (idx == LAST_IDX) begin
            cur_byte = ~csum;
        end else begin
            cur_byte = pay_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            csum         <= 8'h00;
            pay_q        <= '0;
            bus.trmt     <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.busy     <= 1'b0;
            bus.frm_done <= 1'b0;
        end else begin
            bus.trmt     <= 1'b0;
            bus.frm_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.snd) begin
                        pay_q    <= bus.payload;
                        idx      <= '0;
                        csum     <= 8'h00;
                        bus.busy <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.tx_done) begin
                        bus.trmt    <= 1'b1;
                        bus.tx_data <= cur_byte;
                        if (idx != '0 && idx != LAST_IDX) begin
                            csum <= csum + cur_byte;
                        end
                        state <= S_GAP;
                    end
                end
                // The transmitter still reports done for one clock after trmt; skip that sample.
                S_GAP: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.tx_done) begin
                        if (idx < LAST_IDX) begin
                            idx   <= idx + IW'(1);
                            state <= S_LOAD;
                        end else begin
                            bus.busy     <= 1'b0;
                            bus.frm_done <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_seq.sv
// Self-checking bench: a frame-level model predicts trmt/tx_data/busy/frm_done every cycle,
// and logged frames are pinned against hand-computed byte sequences.
module tb_uart_frame_seq;
    localparam int PB        = 4;
    localparam int NB        = PB + 2;
    localparam int BYTE_TIME = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_seq_if #(.PAYLOAD_BYTES(PB)) bus ();

    uart_frame_seq #(.PAYLOAD_BYTES(PB), .HEADER(8'hA5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte transmitter: keeps tx_done high one clock after trmt, then shifts for BYTE_TIME clocks.
    logic tx_idle  = 1'b1;
    logic hold_low = 1'b0;
    int   tx_cnt   = 0;
    bit   tx_pend  = 1'b0;
    assign bus.tx_done = tx_idle & ~hold_low;

    always @(negedge clk) begin
        if (bus.trmt === 1'b1) begin
            tx_pend = 1'b1;
        end else if (tx_pend) begin
            tx_pend = 1'b0;
            tx_cnt  = BYTE_TIME;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        tx_idle = (tx_cnt == 0);
    end

    function automatic void frame_bytes(input logic [8*PB-1:0] p, output logic [7:0] b[NB]);
        int sum = 0;
        b[0] = 8'hA5;
        for (int i = 0; i < PB; i++) begin
            b[i+1] = p[8*i +: 8];
            sum    = sum + int'(p[8*i +: 8]);
        end
        b[NB-1] = ~8'(sum % 256);
    endfunction

    // Frame model: a byte is finished at the first tx_done sample at least two edges after it
    // was issued; the next byte goes out at the first later edge that sees tx_done.
    logic [7:0] m_q[$];
    logic [7:0] m_fb[NB];
    bit         m_active   = 1'b0;
    bit         m_inflight = 1'b0;
    bit         m_valid    = 1'b0;
    int         m_since    = 0;
    logic       exp_trmt   = 1'b0;
    logic       exp_busy   = 1'b0;
    logic       exp_frm    = 1'b0;
    logic [7:0] exp_data   = 8'h00;

    always @(posedge clk) begin
        m_valid  = 1'b1;
        exp_trmt = 1'b0;
        exp_frm  = 1'b0;
        if (rst) begin
            m_active   = 1'b0;
            m_inflight = 1'b0;
            m_q.delete();
            exp_busy   = 1'b0;
        end else if (!m_active) begin
            if (bus.snd) begin
                frame_bytes(bus.payload, m_fb);
                m_q.delete();
                for (int i = 0; i < NB; i++) m_q.push_back(m_fb[i]);
                m_active   = 1'b1;
                m_inflight = 1'b0;
                exp_busy   = 1'b1;
            end
        end else if (!m_inflight) begin
            if (bus.tx_done) begin
                exp_trmt   = 1'b1;
                exp_data   = m_q.pop_front();
                m_inflight = 1'b1;
                m_since    = 0;
            end
        end else begin
            m_since++;
            if (m_since >= 2 && bus.tx_done) begin
                m_inflight = 1'b0;
                if (m_q.size() == 0) begin
                    m_active = 1'b0;
                    exp_busy = 1'b0;
                    exp_frm  = 1'b1;
                end
            end
        end
    end

    logic [7:0] log_buf[16][8];
    int         frame_len[16];
    int         frame_idx = 0;
    int         cur_len   = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("trmt", 32'(bus.trmt), 32'(exp_trmt));
            checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
            checkOutput("frm_done", 32'(bus.frm_done), 32'(exp_frm));
            if (exp_trmt) checkOutput("tx_data", 32'(bus.tx_data), 32'(exp_data));
            if (rst) begin
                cur_len = 0;
            end else begin
                if (bus.trmt === 1'b1 && cur_len < 8 && frame_idx < 16) begin
                    log_buf[frame_idx][cur_len] = bus.tx_data;
                    cur_len++;
                end
                if (bus.frm_done === 1'b1 && frame_idx < 16) begin
                    frame_len[frame_idx] = cur_len;
                    frame_idx++;
                    cur_len = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [8*PB-1:0] p);
        bus.snd     = s;
        bus.payload = p;
    endtask

    task automatic sendPulse(input logic [8*PB-1:0] p);
        applyStimulus(1'b1, p);
        step(1);
        bus.snd = 1'b0;
    endtask

    task automatic waitFrames(input int target);
        int n = 0;
        while (frame_idx < target && n < 1000) begin
            step(1);
            n++;
        end
        checkOutput("frame_count", 32'(frame_idx), 32'(target));
    endtask

    task automatic checkFrame(input int f, input logic [7:0] exp[NB]);
        checkOutput($sformatf("frame%0d_len", f), 32'(frame_len[f]), 32'(NB));
        for (int i = 0; i < NB; i++) begin
            checkOutput($sformatf("frame%0d_byte%0d", f, i), 32'(log_buf[f][i]), 32'(exp[i]));
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_trmt", 32'(bus.trmt), 32'(0));
        checkOutput("rst_busy", 32'(bus.busy), 32'(0));
        checkOutput("rst_frm_done", 32'(bus.frm_done), 32'(0));
        checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h00);
    endtask

    logic [7:0] exp_a[NB] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    logic [7:0] exp_b[NB] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
    logic [7:0] exp_c[NB] = '{8'hA5, 8'h10, 8'h20, 8'h40, 8'h80, 8'h0F};
    logic [7:0] exp_d[NB] = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
    logic [7:0] exp_e[NB] = '{8'hA5, 8'h01, 8'h01, 8'h01, 8'h01, 8'hFB};
    logic [7:0] exp_f[NB] = '{8'hA5, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'hD1};
    logic [7:0] pin_fb[NB];

    initial begin
        int n;
        rst = 1'b1;
        applyStimulus(1'b1, 32'h04030201);

        frame_bytes(32'h04030201, pin_fb);
        for (int i = 0; i < NB; i++) checkOutput($sformatf("model_byte%0d", i), 32'(pin_fb[i]), 32'(exp_a[i]));
        frame_bytes(32'hFFFFFFFF, pin_fb);
        checkOutput("model_wrap_csum", 32'(pin_fb[NB-1]), 32'h03);

        // Reset held with snd high: nothing may start.
        step(2);
        checkReset();
        bus.snd = 1'b0;
        rst     = 1'b0;
        step(3);

        sendPulse(32'h04030201);
        waitFrames(1);
        checkFrame(0, exp_a);

        sendPulse(32'hFFFFFFFF);
        waitFrames(2);
        checkFrame(1, exp_b);

        // snd held through a frame while payload changes mid-flight.
        applyStimulus(1'b1, 32'h80402010);
        step(30);
        bus.payload = 32'h11223344;
        waitFrames(3);
        step(1);
        checkOutput("busy_back_to_back", 32'(bus.busy), 32'(1));
        bus.snd = 1'b0;
        waitFrames(4);
        checkFrame(2, exp_c);
        checkFrame(3, exp_d);

        // Transmitter busy when the request arrives.
        hold_low = 1'b1;
        step(1);
        sendPulse(32'h01010101);
        step(5);
        checkOutput("held_busy", 32'(bus.busy), 32'(1));
        checkOutput("held_trmt", 32'(bus.trmt), 32'(0));
        hold_low = 1'b0;
        waitFrames(5);
        checkFrame(4, exp_e);

        // Reset while payload byte 2 is shifting.
        sendPulse(32'h04030201);
        n = 0;
        while (cur_len < 3 && n < 1000) begin
            step(1);
            n++;
        end
        checkOutput("reached_byte2", 32'(cur_len), 32'(3));
        step(4);
        rst = 1'b1;
        step(1);
        checkReset();
        rst = 1'b0;
        sendPulse(32'h0A0B0C0D);
        step(2);
        checkOutput("post_rst_busy", 32'(bus.busy), 32'(1));
        checkOutput("post_rst_trmt", 32'(bus.trmt), 32'(0));
        waitFrames(6);
        checkFrame(5, exp_f);

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_seq.md
Name: uart_frame_seq

Overview:
Frame sequencer that owns the byte-level UART transmitter and sends one fixed-length telemetry frame per request. A frame is a header byte, then PAYLOAD_BYTES payload bytes (LSB byte first), then an 8-bit checksum byte. The block issues one-clock trmt pulses with tx_data and paces each byte off the transmitter's tx_done. It sits between the telemetry/command logic and the UART transmitter.

Parameters:
PAYLOAD_BYTES, 4, number of payload bytes per frame; legal range 1..8.
HEADER, 8'hA5, constant first byte of every frame.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
snd  input  1  frame request, sampled each clk
payload  input  8*PAYLOAD_BYTES  frame payload; byte i = payload[8i+7:8i]; captured when snd is accepted
tx_done  input  1  transmitter done/idle flag; high when idle, low while a byte is shifting
trmt  output  1  one-clock pulse starting a byte on the transmitter
tx_data  output  8  byte presented to the transmitter; valid while trmt=1
busy  output  1  high from snd acceptance until frame completion
frm_done  output  1  one-clock pulse when the checksum byte finishes

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, trmt=0, tx_data=8'h00, busy=0, frm_done=0, byte index=0, checksum accumulator=0. Reset mid-frame abandons the frame immediately. The next frame still waits for tx_done=1 before its first trmt.
- trmt, tx_data, busy and frm_done are registered outputs with no combinational paths from inputs.
- States:
  - IDLE
  - LOAD: issue a byte.
  - GAP: one cycle that masks stale tx_done.
  - WAIT: wait for the byte to finish.
- IDLE: if snd=1, latch payload into an internal register, clear index and checksum, set busy=1, and go to LOAD. If snd=0, stay. frm_done=0.
- LOAD: if tx_done=1, register trmt=1 and tx_data=current byte, then go to GAP. If tx_done=0, hold LOAD with trmt=0. This covers a transmitter still busy at request time or after a mid-frame reset.
- Current byte by index:
  - idx 0 = HEADER
  - idx 1..PAYLOAD_BYTES = payload byte idx-1
  - idx PAYLOAD_BYTES+1 = checksum
- GAP: trmt=0. Unconditionally go to WAIT. tx_done is ignored in this cycle, because the transmitter deasserts tx_done one clock after trmt.
- WAIT: on tx_done=1:
  - If idx < PAYLOAD_BYTES+1: idx <= idx+1 and go to LOAD.
  - Otherwise: busy <= 0, frm_done <= 1 for one cycle, and go to IDLE.
- Checksum:
  - Accumulator is 8-bit, wraps mod 256.
  - Each payload byte (not the header) is added when issued in LOAD.
  - Transmitted checksum = bitwise NOT of the accumulator after the last payload byte.
- Latency: with tx_done=1, snd sampled at edge k gives busy=1 after edge k and the first trmt=1 after edge k+1. Consecutive trmt pulses are spaced by the transmitter byte time plus 3 clocks.
- Handshakes and boundaries:
  - snd while busy=1 is ignored, with no queuing.
  - snd in the same cycle frm_done is asserted is accepted (state is already IDLE) and starts a new frame.
  - payload changes after acceptance do not affect the frame in flight.
  - Exactly PAYLOAD_BYTES+2 trmt pulses per frame.
  - The index counter is sized for PAYLOAD_BYTES+1 and never wraps.

Test Plan:
- Reset with rst=1 for 2 cycles while snd=1 -> trmt=0, busy=0, frm_done=0, tx_data=00; no trmt ever issued until rst=0.
- PAYLOAD_BYTES=4, payload=32'h04030201, snd pulse, transmitter model ~20 clk/byte -> tx_data sequence A5,01,02,03,04,F5; exactly 6 single-cycle trmt pulses; busy high throughout; one frm_done pulse coinciding with busy falling.
- payload=32'hFFFFFFFF -> bytes A5,FF,FF,FF,FF,03 (sum 0x3FC wraps to FC, NOT = 03).
- snd held high for whole frame plus payload changed mid-frame -> only one frame in flight with original bytes; a second frame starts in the cycle after frm_done, with header A5 again.
- tx_done held low when snd arrives -> busy=1 but no trmt until tx_done rises; first trmt follows on the next edge.
- rst pulsed during payload byte 2, with the transmitter still shifting (tx_done=0) -> outputs return to reset values; a new snd gives first trmt only after tx_done=1, and the new frame starts with A5 and a correct checksum.
